tone_period_meter: RTL and testbench
====================================

Name: tone_period_meter

Overview:
- Receive-side counterpart of the speaker tone generator: samples a square-wave tone input and measures its period in CLK cycles.
- Outputs the latest period with a one-cycle valid strobe, plus a tone-present flag.
- Used for loopback self-test of generated notes and for pitch detection on external square-wave sources.
- Runs on the 16 MHz board clock.

Parameters:
- CNT_W, 20, width of the cycle counter and PERIOD output.
- MIN_PERIOD, 64, minimum accepted period in cycles; rising edges arriving earlier are glitches and are ignored.
- TIMEOUT_CYCLES, 1000000, cycles without an accepted edge before the tone is declared absent (62.5 ms at 16 MHz). Must be less than 2^CNT_W.

Ports:
- CLK  input  1  16 MHz system clock.
- RST_N  input  1  asynchronous active-low reset.
- TONE_IN  input  1  asynchronous square-wave tone input.
- PERIOD  output  CNT_W  last accepted period, in CLK cycles.
- PERIOD_VALID  output  1  one-cycle strobe; PERIOD was updated this cycle.
- TONE_PRESENT  output  1  level; a valid tone is currently being measured.
- HIGH_CYCLES  output  CNT_W  present only with TONE_DUTY_EN; see Optional Feature.

Behaviour:
- Reset is asynchronous and active-low. It clears all state: synchronizer flops, counter, state, PERIOD=0, PERIOD_VALID=0, TONE_PRESENT=0, HIGH_CYCLES=0.
- Synchronizer: TONE_IN passes through a 2-flop synchronizer, then a previous-sample register. A rising edge (rise) is synced=1 and prev=0, and is detected 3 cycles after the input transition.
- States:
  - IDLE: counter held at 0.
  - ARMED: one edge seen, counting.
  - LOCKED: measuring continuously.
- Counter (cnt): increments by 1 every cycle in ARMED or LOCKED. On an accepted edge it reloads to 1 on the next cycle, so at the edge cycle cnt equals the exact period in cycles.
- IDLE + rise: go to ARMED, cnt <= 1. No PERIOD_VALID.
- ARMED/LOCKED + rise with cnt < MIN_PERIOD: glitch. The edge is ignored and cnt keeps counting.
- ARMED/LOCKED + rise with cnt >= MIN_PERIOD (accepted edge):
  - PERIOD <= cnt, PERIOD_VALID=1 on the following cycle.
  - Go to LOCKED, TONE_PRESENT <= 1, cnt <= 1.
- Timeout: in ARMED or LOCKED, if cnt == TIMEOUT_CYCLES and there is no accepted edge that cycle:
  - go to IDLE, cnt <= 0, TONE_PRESENT <= 0.
  - PERIOD holds its last value. No PERIOD_VALID.
- Simultaneous edge and timeout: an accepted edge at cnt == TIMEOUT_CYCLES wins. It is measured normally; no timeout.
- cnt never exceeds TIMEOUT_CYCLES, so no wrap-around is possible.
- PERIOD_VALID lasts exactly one cycle per accepted edge, never two in consecutive cycles (guaranteed because MIN_PERIOD > 1).
- Falling edges do not affect the period measurement.
- Reset mid-operation: outputs clear immediately. After release, the state machine restarts in IDLE.
  - If TONE_IN is high at release, the synchronizer's 0→1 transition counts as a rise and arms the meter. The first PERIOD is reported only after the next accepted edge.

Optional Feature:
- Macro TONE_DUTY_EN.
- Defined:
  - Adds the HIGH_CYCLES output and a high-time counter.
  - The counter reloads to 1 on each accepted edge and increments on every cycle that the synced level is 1. Glitch pulses inside a period are included in the count.
  - On the accepted edge, HIGH_CYCLES is latched together with PERIOD and shares the PERIOD_VALID strobe.
  - Reset value is 0. Timeout leaves it unchanged.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package tone_meter_pkg:
  - state enum {IDLE, ARMED, LOCKED}.
  - default constants CNT_W_DEF=20, MIN_PERIOD_DEF=64, TIMEOUT_DEF=1000000.
  - constant CLK_HZ=16000000.
- Sub-module tone_sync_edge: 2-flop synchronizer, previous-sample register, rise output, synced level output. Asynchronous active-low reset, all flops reset to 0.

Test Plan:
- Reset: hold RST_N=0 with TONE_IN toggling → PERIOD=0, PERIOD_VALID=0, TONE_PRESENT=0 throughout. HIGH_CYCLES=0 when enabled.
- Generator loopback: square wave with period 56818 cycles, high 24050 cycles → no strobe after the first rise. After the second rise, PERIOD=56818 with a one-cycle PERIOD_VALID and TONE_PRESENT=1. Repeats every 56818 cycles.
- Glitch rejection: with the locked 56818-cycle tone, inject a 10-cycle high pulse 1000 cycles after a rising edge → no strobe at the glitch. The next PERIOD is 56818.
- Timeout: stop the tone, held low → TONE_PRESENT falls exactly 1000000 cycles after the last accepted edge's cnt reload (plus synchronizer delay). PERIOD keeps 56818. Restarting the tone needs two rises before a new PERIOD_VALID.
- Boundary: period of exactly MIN_PERIOD=64 → accepted, PERIOD=64. Period 63 → rejected, and the following rise is measured as 126. Edge arriving exactly at cnt=TIMEOUT_CYCLES → accepted, no timeout.
- Reset mid-measurement, then release with TONE_IN high → outputs clear asynchronously, meter arms on release. The first PERIOD_VALID comes at the next rise.
- With TONE_DUTY_EN, the HIGH_CYCLES check runs in the generator loopback scenario → HIGH_CYCLES=24050 with each strobe.

Source files
------------

// File: rtl/tone_meter_pkg.sv
// Shared types and default constants for the tone period meter.
package tone_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int CNT_W_DEF      = 20;
    localparam int MIN_PERIOD_DEF = 64;
    localparam int TIMEOUT_DEF    = 1000000;
    localparam int CLK_HZ         = 16000000;

endpackage

// File: rtl/tone_sync_edge.sv
// Two-flop synchronizer for the tone input, followed by a previous-sample
// register for rising-edge detection.
module tone_sync_edge (
    input  logic CLK,
    input  logic RST_N,
    input  logic din,
    output logic synced,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    // NOTE: sequential state uses non-blocking assignments so the three stages
    // shift together instead of collapsing into one flop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign synced = sync;
    assign rise   = sync & ~prev;

endmodule

// File: rtl/tone_period_meter.sv
// Measures the period of a square-wave tone in CLK cycles, with glitch
// rejection and tone-absent timeout. Define TONE_DUTY_EN to add HIGH_CYCLES.
module tone_period_meter
    import tone_meter_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int MIN_PERIOD     = MIN_PERIOD_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             TONE_IN,
    output logic [CNT_W-1:0] PERIOD,
    output logic             PERIOD_VALID,
`ifdef TONE_DUTY_EN
    output logic [CNT_W-1:0] HIGH_CYCLES,
`endif
    output logic             TONE_PRESENT
);

    localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    logic             synced;
    logic             rise;
    logic             accept;
    state_t           state,   state_nxt;
    logic [CNT_W-1:0] cnt,     cnt_nxt;
    logic [CNT_W-1:0] period_nxt;
    logic             valid_nxt;
    logic             present_nxt;

    tone_sync_edge u_sync (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .din    (TONE_IN),
        .synced (synced),
        .rise   (rise)
    );

    assign accept = rise && (state != IDLE) && (cnt >= MIN_CNT);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        period_nxt  = PERIOD;
        valid_nxt   = 1'b0;
        present_nxt = TONE_PRESENT;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (rise) begin
                    state_nxt = ARMED;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ARMED, LOCKED: begin
                // An accepted edge at the timeout count still wins.
                if (accept) begin
                    state_nxt   = LOCKED;
                    cnt_nxt     = CNT_W'(1);
                    period_nxt  = cnt;
                    valid_nxt   = 1'b1;
                    present_nxt = 1'b1;
                end else if (cnt == TIMEOUT_CNT) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    present_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            cnt          <= '0;
            PERIOD       <= '0;
            PERIOD_VALID <= 1'b0;
            TONE_PRESENT <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            PERIOD       <= period_nxt;
            PERIOD_VALID <= valid_nxt;
            TONE_PRESENT <= present_nxt;
        end
    end

`ifdef TONE_DUTY_EN
    logic [CNT_W-1:0] high_cnt, high_cnt_nxt;
    logic [CNT_W-1:0] high_out_nxt;

    // The arming edge also starts a high-time window so the first report is sane.
    always_comb begin
        high_cnt_nxt = high_cnt;
        high_out_nxt = HIGH_CYCLES;
        if (accept) begin
            high_out_nxt = high_cnt;
            high_cnt_nxt = CNT_W'(1);
        end else if (state == IDLE) begin
            if (rise) high_cnt_nxt = CNT_W'(1);
        end else if (synced) begin
            high_cnt_nxt = high_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            high_cnt    <= '0;
            HIGH_CYCLES <= '0;
        end else begin
            high_cnt    <= high_cnt_nxt;
            HIGH_CYCLES <= high_out_nxt;
        end
    end
`else
    logic level_unused;
    assign level_unused = synced;
`endif

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter, with timeout scaled to 2000 cycles
// and tone periods scaled to 568 cycles to keep the run short.
module tb_tone_period_meter;

    localparam int W = 20;

    logic         CLK;
    logic         RST_N;
    logic         TONE_IN;
    logic [W-1:0] PERIOD;
    logic         PERIOD_VALID;
    logic         TONE_PRESENT;
`ifdef TONE_DUTY_EN
    logic [W-1:0] HIGH_CYCLES;
`endif

    typedef struct {
        int           cyc;
        logic [W-1:0] per;
        logic [W-1:0] hi;
    } strobe_t;

    strobe_t q[$];
    int      cyc;
    int      fall_cyc;
    logic    prev_valid;
    logic    prev_present;
    int      n_checks;
    int      n_fail;

    tone_period_meter #(
        .CNT_W          (W),
        .MIN_PERIOD     (64),
        .TIMEOUT_CYCLES (2000)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .TONE_IN      (TONE_IN),
        .PERIOD       (PERIOD),
        .PERIOD_VALID (PERIOD_VALID),
`ifdef TONE_DUTY_EN
        .HIGH_CYCLES  (HIGH_CYCLES),
`endif
        .TONE_PRESENT (TONE_PRESENT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Strobe logger: records every PERIOD_VALID pulse and the TONE_PRESENT fall.
    always @(negedge CLK) begin
        if (PERIOD_VALID === 1'b1) begin
            strobe_t s;
            check("valid_one_cycle", 32'(prev_valid), 0);
            s.cyc = cyc;
            s.per = PERIOD;
`ifdef TONE_DUTY_EN
            s.hi  = HIGH_CYCLES;
`else
            s.hi  = '0;
`endif
            q.push_back(s);
        end
        if (prev_present === 1'b1 && TONE_PRESENT === 1'b0) fall_cyc <= cyc;
        prev_valid   <= PERIOD_VALID;
        prev_present <= TONE_PRESENT;
    end

    task automatic hold(input logic lvl, input int n);
        TONE_IN = lvl;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic tone_period(input int p, input int h);
        hold(1'b1, h);
        hold(1'b0, p - h);
    endtask

    task automatic check_strobe(input string tag, input int idx, input int per, input int hi);
        check({tag, "_period"}, 32'(q[idx].per), per);
`ifdef TONE_DUTY_EN
        check({tag, "_high"}, 32'(q[idx].hi), hi);
`else
        if (hi < 0) check({tag, "_high"}, 32'(q[idx].hi), 0);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        fall_cyc = 0;
        RST_N    = 1'b0;
        TONE_IN  = 1'b0;
        @(posedge CLK);
        #1;

        // Reset held while the input toggles.
        for (int i = 0; i < 6; i++) begin
            TONE_IN = i[0];
            @(posedge CLK);
            #1;
            check("rst_period", 32'(PERIOD), 0);
            check("rst_valid", 32'(PERIOD_VALID), 0);
            check("rst_present", 32'(TONE_PRESENT), 0);
`ifdef TONE_DUTY_EN
            check("rst_high", 32'(HIGH_CYCLES), 0);
`endif
        end
        TONE_IN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        hold(1'b0, 10);

        // Loopback tone: first rise only arms.
        q.delete();
        tone_period(568, 240);
        check("arm_strobes", q.size(), 0);
        check("arm_present", 32'(TONE_PRESENT), 0);
        repeat (3) tone_period(568, 240);
        check("loop_strobes", q.size(), 3);
        for (int i = 0; i < 3; i++) check_strobe("loop", i, 568, 240);
        check("loop_spacing1", q[1].cyc - q[0].cyc, 568);
        check("loop_spacing2", q[2].cyc - q[1].cyc, 568);
        check("loop_present", 32'(TONE_PRESENT), 1);

        // Glitch pulse 30 cycles into a period, below MIN_PERIOD.
        q.delete();
        hold(1'b1, 20);
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b0, 528);
        tone_period(568, 240);
        check("glitch_strobes", q.size(), 2);
        check_strobe("glitch_pre", 0, 568, 240);
        check_strobe("glitch_post", 1, 568, 30);
        check("glitch_spacing", q[1].cyc - q[0].cyc, 568);

        // MIN_PERIOD boundary: 64 accepted, 63 rejected and folded into 126.
        q.delete();
        tone_period(64, 32);
        tone_period(63, 31);
        tone_period(63, 31);
        tone_period(568, 240);
        check("bound_strobes", q.size(), 3);
        check_strobe("bound_prev", 0, 568, 240);
        check_strobe("bound_64", 1, 64, 32);
        check_strobe("bound_126", 2, 126, 62);

        // Edge exactly at the timeout count is accepted.
        q.delete();
        tone_period(2000, 240);
        hold(1'b1, 240);
        hold(1'b0, 10);
        check("tie_strobes", q.size(), 2);
        check_strobe("tie_prev", 0, 568, 240);
        check_strobe("tie_2000", 1, 2000, 240);
        check("tie_present", 32'(TONE_PRESENT), 1);

        // Tone stops: timeout 2000 cycles after the reload.
        hold(1'b0, 2100);
        check("to_present", 32'(TONE_PRESENT), 0);
        check("to_fall_delay", fall_cyc - q[1].cyc, 2000);
        check("to_period_kept", 32'(PERIOD), 2000);
        check("to_no_strobe", q.size(), 2);

        // Restart needs two rises.
        q.delete();
        tone_period(568, 240);
        check("re_arm_strobes", q.size(), 0);
        check("re_arm_present", 32'(TONE_PRESENT), 0);
        tone_period(568, 240);
        check("re_strobes", q.size(), 1);
        check_strobe("re", 0, 568, 240);
        check("re_present", 32'(TONE_PRESENT), 1);

        // Asynchronous reset mid-measurement, released with the input high.
        hold(1'b1, 100);
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_period", 32'(PERIOD), 0);
        check("mid_rst_valid", 32'(PERIOD_VALID), 0);
        check("mid_rst_present", 32'(TONE_PRESENT), 0);
        repeat (3) @(posedge CLK);
        #1;
        q.delete();
        RST_N = 1'b1;
        hold(1'b1, 100);
        hold(1'b0, 200);
        check("rel_arm_strobes", q.size(), 0);
        check("rel_arm_present", 32'(TONE_PRESENT), 0);
        hold(1'b1, 20);
        check("rel_strobes", q.size(), 1);
        check("rel_period", 32'(q[0].per), 300);
        check("rel_present", 32'(TONE_PRESENT), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
